// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier: shift-add mantissa product,
// RNE rounding, flush-to-zero, denormals-are-zero, fixed latency for all operand classes.
module fp_mul_seq #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] R,
    output logic [4:0]  flags
);

    localparam int unsigned N        = 24 / BITS_PER_CYCLE;
    localparam int unsigned PW       = 24 + BITS_PER_CYCLE;
    localparam logic [4:0]  CNT_LAST = 5'(N - 1);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_NORM,
        S_DONE
    } state_t;

    state_t              state_q;
    logic                busy_q;
    logic                done_q;
    logic [31:0]         r_q;
    logic [4:0]          flags_q;
    logic [23:0]         mcand_q;
    logic [23:0]         mplier_q;
    logic [47:0]         acc_q;
    logic signed [9:0]   exp_q;
    logic                sign_q;
    logic [4:0]          cnt_q;
    logic                special_q;
    logic [31:0]         spec_r_q;
    logic [4:0]          spec_f_q;

    // Operand classification (exponent 0 counts as zero)
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        nan_a, nan_b, snan_a, snan_b;
    logic        inf_a, inf_b, zero_a, zero_b;
    logic        prod_sign;
    logic signed [9:0] exp_sum;

    assign ea        = A[30:23];
    assign eb        = B[30:23];
    assign fa        = A[22:0];
    assign fb        = B[22:0];
    assign nan_a     = (ea == 8'hFF) && (fa != '0);
    assign nan_b     = (eb == 8'hFF) && (fb != '0);
    assign snan_a    = nan_a && !fa[22];
    assign snan_b    = nan_b && !fb[22];
    assign inf_a     = (ea == 8'hFF) && (fa == '0);
    assign inf_b     = (eb == 8'hFF) && (fb == '0);
    assign zero_a    = (ea == '0);
    assign zero_b    = (eb == '0);
    assign prod_sign = A[31] ^ B[31];
    assign exp_sum   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

    logic        special_d;
    logic [31:0] spec_r_d;
    logic [4:0]  spec_f_d;

    always_comb begin
        special_d = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;
        spec_r_d  = '0;
        spec_f_d  = '0;
        if (nan_a || nan_b) begin
            spec_r_d = QNAN;
            spec_f_d = {snan_a | snan_b, 4'b0000};
        end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            spec_r_d = QNAN;
            spec_f_d = 5'b10000;
        end else if (inf_a || inf_b) begin
            spec_r_d = {prod_sign, 8'hFF, 23'd0};
        end else begin
            spec_r_d = {prod_sign, 31'd0};
        end
    end

    // Shift-add step: the new partial product enters the top half, then the
    // whole accumulator shifts right so the final value lands at bit 0.
    logic [PW-1:0]               pp_sum;
    logic [47+BITS_PER_CYCLE:0]  acc_wide;
    logic [47:0]                 acc_step;

    always_comb begin
        pp_sum   = PW'(acc_q[47:24]) + PW'(mcand_q) * PW'(mplier_q[BITS_PER_CYCLE-1:0]);
        acc_wide = {pp_sum, acc_q[23:0]};
        acc_step = acc_wide[47+BITS_PER_CYCLE:BITS_PER_CYCLE];
    end

    logic              norm_hi;
    logic [22:0]       man_pre;
    logic              guard, sticky, round_up;
    logic [23:0]       man_inc;
    logic signed [9:0] e_fin;
    logic [31:0]       res_r;
    logic [4:0]        res_f;

    always_comb begin
        norm_hi  = acc_q[47];
        man_pre  = norm_hi ? acc_q[46:24] : acc_q[45:23];
        guard    = norm_hi ? acc_q[23] : acc_q[22];
        sticky   = norm_hi ? (|acc_q[22:0]) : (|acc_q[21:0]);
        round_up = guard & (sticky | man_pre[0]);
        // A carry out of rounding leaves the low 23 bits zero, i.e. mantissa 1.0
        man_inc  = {1'b0, man_pre} + 24'(round_up);
        e_fin    = exp_q + $signed(10'(norm_hi)) + $signed(10'(man_inc[23]));
        res_r    = '0;
        res_f    = '0;
        if (special_q) begin
            res_r = spec_r_q;
            res_f = spec_f_q;
        end else if (e_fin >= 10'sd255) begin
            res_r = {sign_q, 8'hFF, 23'd0};
            res_f = 5'b00101;
        end else if (e_fin <= 10'sd0) begin
            res_r = {sign_q, 31'd0};
            res_f = 5'b00011;
        end else begin
            res_r = {sign_q, e_fin[7:0], man_inc[22:0]};
            res_f = {4'b0000, guard | sticky};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            r_q       <= '0;
            flags_q   <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            cnt_q     <= '0;
            special_q <= 1'b0;
            spec_r_q  <= '0;
            spec_f_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q   <= {1'b1, fa};
                        mplier_q  <= {1'b1, fb};
                        sign_q    <= prod_sign;
                        exp_q     <= exp_sum;
                        acc_q     <= '0;
                        cnt_q     <= CNT_LAST;
                        special_q <= special_d;
                        spec_r_q  <= spec_r_d;
                        spec_f_q  <= spec_f_d;
                        busy_q    <= 1'b1;
                        state_q   <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_step;
                    mplier_q <= mplier_q >> BITS_PER_CYCLE;
                    cnt_q    <= cnt_q - 5'd1;
                    if (cnt_q == '0) begin
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_q     <= res_r;
                    flags_q <= res_f;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign R     = r_q;
    assign flags = flags_q;

endmodule
